match_reader: RTL and testbench

- Read side of the sniffer's match memory. The controller writes matched-packet records into memory; this block drains those records.
- It tracks the writer's next-free pointer against its own read pointer and fetches one word at a time when a whole record is present.
- Each word is presented on a valid/ready stream toward the host/output interface, with start/end-of-record markers.
- A sticky error flag covers memory read timeouts.

---
 rtl/match_reader.sv | 193 +++++++++++++++++++
 tb/tb_match_reader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/match_reader.sv
// match_reader: drains matched-packet records from the sniffer's match memory.
// Compares the writer's next-free pointer against the read pointer and starts
// a record only when all RECORD_WORDS words are present. It then fetches one
// word per REQ/WAIT/SEND pass and streams each word out with sop/eop markers.
// A read that gets no mem_rvalid within TIMEOUT cycles sets a sticky err flag,
// and the read pointer skips past the corrupt record.
// Optional build macro: MATCH_READER_REC_COUNT_EN enables a saturating 16-bit
// delivered-record counter on rec_count. Without it, rec_count is tied to 0.
//
// Output stream handshake: a word transfers on a rising edge where
// out_valid=1 and out_ready=1. While out_valid=1 and out_ready=0, out_data,
// out_sop and out_eop do not change. Once out_valid is asserted it stays high
// until the word is accepted. out_sop and out_eop have meaning only while
// out_valid=1.
module match_reader #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int RECORD_WORDS = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [ADDR_W-1:0] wr_ptr,
  output logic              mem_rdreq,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic              busy,
  output logic              err,
  input  logic              clr_err,
  output logic [15:0]       rec_count,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_SEND  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] REC_LEN  = ADDR_W'(RECORD_WORDS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(RECORD_WORDS - 1);
  localparam logic [7:0]        TO_LAST  = 8'(TIMEOUT - 1);

  state_t              state_q;
  logic [ADDR_W-1:0]   rd_ptr_q;
  logic [ADDR_W-1:0]   rec_base_q;
  logic [ADDR_W-1:0]   word_idx_q;
  logic [7:0]          wait_cnt_q;
  logic                mem_rdreq_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_valid_q;
  logic                out_sop_q;
  logic                out_eop_q;
  logic                busy_q;
  logic                err_q;

  logic [ADDR_W-1:0]   avail_d;
  logic [ADDR_W-1:0]   rd_ptr_inc_d;

  // Occupancy and next read address, both modulo 2^ADDR_W so wrap is implicit.
  assign avail_d      = wr_ptr - rd_ptr_q;
  assign rd_ptr_inc_d = rd_ptr_q + 1'b1;

  // Main control FSM. All outputs are registered and set on state transitions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      rec_base_q  <= '0;
      word_idx_q  <= '0;
      wait_cnt_q  <= '0;
      mem_rdreq_q <= 1'b0;
      mem_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // The read strobe is high only in the cycle spent in REQ.
      mem_rdreq_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Start only on a whole record. A partial record waits for the writer.
          if (enable && (avail_d >= REC_LEN)) begin
            rec_base_q  <= rd_ptr_q;
            word_idx_q  <= '0;
            mem_rdreq_q <= 1'b1;
            mem_addr_q  <= rd_ptr_q;
            busy_q      <= 1'b1;
            state_q     <= S_REQ;
          end
        end
        S_REQ: begin
          wait_cnt_q <= '0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          // rvalid is checked first, so data arriving on the last allowed
          // cycle is still accepted.
          if (mem_rvalid) begin
            out_data_q  <= mem_rdata;
            out_valid_q <= 1'b1;
            out_sop_q   <= (word_idx_q == '0);
            out_eop_q   <= (word_idx_q == LAST_IDX);
            state_q     <= S_SEND;
          end else if (wait_cnt_q == TO_LAST) begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
            err_q      <= 1'b1;
            rd_ptr_q   <= rec_base_q + REC_LEN;
            state_q    <= S_ERROR;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        S_SEND: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            rd_ptr_q    <= rd_ptr_inc_d;
            if (out_eop_q) begin
              // Going back through IDLE leaves a gap cycle between records.
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              word_idx_q  <= word_idx_q + 1'b1;
              mem_rdreq_q <= 1'b1;
              mem_addr_q  <= rd_ptr_inc_d;
              state_q     <= S_REQ;
            end
          end
        end
        S_ERROR: begin
          if (clr_err) begin
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_rdreq = mem_rdreq_q;
  assign mem_addr  = mem_addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign rd_ptr    = rd_ptr_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign dbg_state = state_q;

`ifdef MATCH_READER_REC_COUNT_EN
  logic [15:0] rec_count_q;
  logic        eop_accept;

  assign eop_accept = (state_q == S_SEND) && out_ready && out_eop_q;

  // Delivered-record counter. It saturates instead of wrapping and is cleared
  // only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rec_count_q <= '0;
    end else if (eop_accept && (rec_count_q != 16'hFFFF)) begin
      rec_count_q <= rec_count_q + 16'd1;
    end
  end

  assign rec_count = rec_count_q;
`else
  assign rec_count = '0;
`endif

endmodule

// File: tb/tb_match_reader.sv
// Directed testbench for match_reader with the default parameters
// (ADDR_W=8, DATA_W=32, RECORD_WORDS=4, TIMEOUT=15).
// The memory model returns 32'hA0 + address one cycle after each read request.
module tb_match_reader;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic        enable = 1'b0;
  logic [7:0]  wr_ptr = '0;
  logic        mem_rdreq;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sop;
  logic        out_eop;
  logic [7:0]  rd_ptr;
  logic        busy;
  logic        err;
  logic        clr_err = 1'b0;
  logic [15:0] rec_count;
  logic [2:0]  dbg_state;

  match_reader dut (
    .clk(clk), .rst(rst), .enable(enable), .wr_ptr(wr_ptr),
    .mem_rdreq(mem_rdreq), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
    .rd_ptr(rd_ptr), .busy(busy), .err(err), .clr_err(clr_err),
    .rec_count(rec_count), .dbg_state(dbg_state)
  );

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ERROR = 3'd4;

`ifdef MATCH_READER_REC_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  // ---------------- memory model and monitor (negedge) ----------------
  bit          mem_en = 1'b1;
  logic        pend_v = 1'b0;
  logic [31:0] pend_d = '0;
  logic [7:0]  got_a[$];
  logic [33:0] got_w[$];
  logic [33:0] exp_q[$];

  always @(negedge clk) begin
    mem_rvalid = pend_v;
    mem_rdata  = pend_d;
    pend_v     = mem_rdreq && mem_en && !rst;
    pend_d     = 32'hA0 + 32'(mem_addr);
    if (mem_rdreq) got_a.push_back(mem_addr);
    if (out_valid && out_ready) got_w.push_back({out_sop, out_eop, out_data});
  end

  // ---------------- driver / check tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int nwords, input int max, input string tag);
    int c = 0;
    while (!((got_w.size() >= nwords) && !busy) && (c < max)) begin
      step();
      c++;
    end
    chk(tag, 64'(c < max), 64'd1);
  endtask

  task automatic check_record(input logic [7:0] base, input string tag);
    logic [7:0]  a;
    logic [33:0] e;
    logic [33:0] g;
    logic [7:0]  ga;
    for (int i = 0; i < 4; i++) begin
      a = base + 8'(i);
      exp_q.push_back({(i == 0), (i == 3), 32'hA0 + 32'(a)});
    end
    for (int i = 0; i < 4; i++) begin
      e  = exp_q.pop_front();
      g  = '1;
      ga = '1;
      if (got_w.size() != 0) g = got_w.pop_front();
      if (got_a.size() != 0) ga = got_a.pop_front();
      chk({tag, "_addr"}, 64'(ga), 64'(base + 8'(i)));
      chk({tag, "_word"}, 64'(g), 64'(e));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int c;
    int naddr;
    logic [7:0] e_addr;

    // Reset: every output low.
    #1 rst = 1'b1;
    #2;
    chk("rst_outs", 64'({out_valid, mem_rdreq, busy, err, out_sop, out_eop}), 64'd0);
    chk("rst_rd_ptr", 64'(rd_ptr), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("rst_count", 64'(rec_count), 64'd0);
    step();
    rst = 1'b0;

    // Partial record (avail 3) never starts.
    wr_ptr = 8'd3; enable = 1'b1; out_ready = 1'b1;
    repeat (10) step();
    chk("partial_no_req", 64'(got_a.size()), 64'd0);
    chk("partial_busy", 64'(busy), 64'd0);

    // First full record, addresses 0..3.
    wr_ptr = 8'd4;
    wait_done(4, 60, "rec1_done");
    check_record(8'd0, "rec1");
    chk("rec1_rd_ptr", 64'(rd_ptr), 64'd4);
    chk("rec1_count", 64'(rec_count), CNT_ON ? 64'd1 : 64'd0);

    // Second record with a 5-cycle stall on word 2.
    wr_ptr = 8'd8;
    c = 0;
    while (got_w.size() < 2 && c < 60) begin step(); c++; end
    chk("rec2_w1_seen", 64'(c < 60), 64'd1);
    out_ready = 1'b0;
    c = 0;
    while (!out_valid && c < 20) begin step(); c++; end
    chk("rec2_w2_valid", 64'(c < 20), 64'd1);
    naddr = got_a.size();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_data", 64'(out_data), 64'h0A6);
      chk("stall_flags", 64'({out_sop, out_eop}), 64'd0);
      step();
    end
    chk("stall_no_req", 64'(got_a.size()), 64'(naddr));
    out_ready = 1'b1;
    wait_done(4, 60, "rec2_done");
    check_record(8'd4, "rec2");
    chk("rec2_rd_ptr", 64'(rd_ptr), 64'd8);

    // Read timeout on the record at base 8.
    mem_en = 1'b0;
    wr_ptr = 8'd12;
    c = 0;
    while (!mem_rdreq && c < 10) begin step(); c++; end
    chk("to_req_seen", 64'(c < 10), 64'd1);
    repeat (15) step();
    chk("to_err_early", 64'(err), 64'd0);
    step();
    chk("to_err", 64'(err), 64'd1);
    chk("to_busy", 64'(busy), 64'd1);
    chk("to_valid", 64'(out_valid), 64'd0);
    chk("to_state", 64'(dbg_state), 64'(ST_ERROR));
    chk("to_rd_ptr", 64'(rd_ptr), 64'd12);
    e_addr = (got_a.size() != 0) ? got_a.pop_front() : 8'hFF;
    chk("to_addr", 64'(e_addr), 64'd8);
    chk("to_one_req", 64'(got_a.size()), 64'd0);
    mem_en = 1'b1;
    step();
    chk("to_err_sticky", 64'(err), 64'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("clr_err", 64'(err), 64'd0);
    chk("clr_idle", 64'(dbg_state), 64'(ST_IDLE));
    chk("clr_busy", 64'(busy), 64'd0);

    // enable low blocks new starts even with plenty available.
    enable = 1'b0;
    wr_ptr = 8'd252;
    repeat (6) step();
    chk("gate_busy", 64'(busy), 64'd0);
    chk("gate_no_req", 64'(got_a.size()), 64'd0);

    // Drain up to 252, then one record that wraps addresses 252..255 -> 0.
    enable = 1'b1;
    c = 0;
    while (!(rd_ptr == 8'd252 && !busy) && c < 1500) begin step(); c++; end
    chk("drain_done", 64'(c < 1500), 64'd1);
    got_a.delete();
    got_w.delete();
    wr_ptr = 8'd0;
    wait_done(4, 60, "wrap_done");
    check_record(8'd252, "wrap");
    chk("wrap_rd_ptr", 64'(rd_ptr), 64'd0);
    chk("wrap_count", 64'(rec_count), CNT_ON ? 64'd63 : 64'd0);
    wr_ptr = 8'd2;
    repeat (8) step();
    chk("wrap_partial", 64'(got_a.size()), 64'd0);

    // Asynchronous reset while word 1 of a record is in SEND.
    wr_ptr = 8'd8;
    c = 0;
    while (!(out_valid && !out_sop) && c < 40) begin step(); c++; end
    chk("ar_w1_seen", 64'(c < 40), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_rd_ptr", 64'(rd_ptr), 64'd0);
    chk("ar_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_count", 64'(rec_count), 64'd0);
    enable = 1'b0;
    step();
    rst = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
